tile_map_renderer: RTL and testbench
====================================

Name: tile_map_renderer

Overview:
- Parametrised tile-map background renderer for the VGA pipeline; successor to the fixed 20x15 maze background.
- Holds a writable tile map (2-bit tile type per cell) instead of a hard-coded matrix; it is initialised by an internal sequencer after reset.
- Converts h_count/v_count into texture-ROM addresses and returns an 8-bit pixel colour with fixed pipeline latency.
- Exposes a second map port so game logic can rewrite cells or query them for collision.

Parameters:
- H_START, 144, first active horizontal count
- V_START, 31, first active vertical count
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines
- TILE_LOG2, 5, log2 of tile edge in pixels (32)
- TEX_LOG2, 4, log2 of texture edge in pixels (16); textures repeat within a tile
- MAP_COLS, 20, tile columns
- MAP_ROWS, 15, tile rows
- ANIM_BITS, 4, width of the animation frame counter

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- h_count  in  10  horizontal count
- v_count  in  10  vertical count
- anim_tick  in  1  single-cycle pulse that advances the animation frame
- map_we  in  1  map write strobe (port B)
- map_addr  in  clog2(MAP_COLS*MAP_ROWS)  map address for port B write/query, row*MAP_COLS+col
- map_wdata  in  2  tile type: 0 grass, 1 brick, 2 flower, 3 empty/black
- map_rdata  out  2  query result, 1 cycle after address
- map_ready  out  1  high once initialisation is complete
- tex_id  out  2  texture select to ROM bank: 0 grass, 1 brick, 2 flower
- tex_addr  out  2*TEX_LOG2  texture pixel address {ty,tx}
- tex_data  in  8  ROM data, valid 1 cycle after tex_id/tex_addr
- anim_frame  out  ANIM_BITS  current animation frame
- color  out  8  pixel colour (RRRGGGBB)

Behaviour:
- Async reset, all outputs zero: color, tex_id, tex_addr, map_rdata, map_ready, anim_frame.
- Reset mid-init or mid-frame aborts everything; init restarts from address 0 after rst_n rises.
- FSM states: INIT, RUN.
- INIT:
  - Entered on reset. Writes one cell per clock, address 0 to N-1, where N = MAP_COLS*MAP_ROWS.
  - Border cells (row 0, row MAP_ROWS-1, col 0, col MAP_COLS-1) get type 1; all others get type 0.
  - map_ready goes high on the clock after the write to N-1, and the FSM moves to RUN.
  - During INIT, port B writes and queries are ignored, map_rdata holds 0, and color is forced to 0.
- RUN is held until reset.
- Port B (RUN only):
  - map_we=1 writes map_wdata at map_addr.
  - map_we=0 reads; map_rdata is registered 1 cycle later.
  - map_addr >= N: write dropped, read returns 0.
- Render pipeline, fixed latency 4 clocks (color at edge k+4 reflects h/v sampled at edge k):
  - S0: px = h_count-H_START, py = v_count-V_START (10-bit). active = h in [H_START, H_START+H_ACTIVE-1] and v in [V_START, V_START+V_ACTIVE-1]. col = px>>TILE_LOG2, row = py>>TILE_LOG2. inmap = active and col<MAP_COLS and row<MAP_ROWS. Port A read issued at row*MAP_COLS+col.
  - S1: tile type returned; px, py and inmap delayed alongside.
  - S2: tex_id/tex_addr registered. tx = px mod 2^TEX_LOG2, ty = py mod 2^TEX_LOG2.
    - Type 2 (flower): flower texture only on 8x8 sub-cells where bit3 of px equals bit3 of py; grass elsewhere.
    - Flower mirroring: if anim_frame MSB = 0, tx is mirrored (2^TEX_LOG2-1-tx).
    - Type 3: tex_id=0 with a black flag set.
  - S3: color <= (inmap and not black and not INIT) ? tex_data : 8'h00.
- Simultaneous port B write and port A read of the same cell: port A returns old data (read-first). The new value appears from the next clock.
- anim_tick: anim_frame increments by 1 per pulse and wraps 2^ANIM_BITS-1 to 0. It is frozen during INIT. Mirroring changes only for pixels entering S2 after the increment.
- The map is N x 2-bit, dual-port synchronous RAM with no reset on its contents; it is initialised only by INIT.

Test Plan:
- Reset release -> map_ready=0 for exactly 300 clocks, rises on clock 301. Querying addr 0 gives 1, addr 21 gives 0, addr 299 gives 1.
- RUN, h=144, v=31 presented at edge k, with the tex_data model returning 8'hA5 -> tex_id=1 and tex_addr=0 at edge k+3, color=8'hA5 at edge k+4. h=100 gives color=0 at k+4.
- Write type 2 at addr 21 (row 1, col 1); render h=144+32+3, v=31+32+0 -> tex_id=2 and tex_addr={0,12} (mirrored, frame 0). After 8 anim_tick pulses -> tex_addr={0,3}.
- Same-cycle port B write type 3 and render read of cell 42 -> first pixel shows old texture; pixels from the next clock show color 0.
- Assert rst_n low for 1 cycle midway through INIT (cell 150) -> outputs 0 immediately, and init restarts so that map_ready rises 301 clocks after release.
- map_addr=300 with map_we=1 -> no cell changes; a read at 300 returns 0.

Source files
------------

// File: rtl/tile_map_renderer.sv
// tile_map_renderer: writable 2-bit tile-map background renderer with a
// self-initialising map, a game-logic map port and animated flower tiles.
module tile_map_renderer #(
    parameter int H_START   = 144,
    parameter int V_START   = 31,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int TILE_LOG2 = 5,
    parameter int TEX_LOG2  = 4,
    parameter int MAP_COLS  = 20,
    parameter int MAP_ROWS  = 15,
    parameter int ANIM_BITS = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [9:0]                           h_count,
    input  logic [9:0]                           v_count,
    input  logic                                 anim_tick,
    input  logic                                 map_we,
    input  logic [$clog2(MAP_COLS*MAP_ROWS)-1:0] map_addr,
    input  logic [1:0]                           map_wdata,
    output logic [1:0]                           map_rdata,
    output logic                                 map_ready,
    output logic [1:0]                           tex_id,
    output logic [2*TEX_LOG2-1:0]                tex_addr,
    input  logic [7:0]                           tex_data,
    output logic [ANIM_BITS-1:0]                 anim_frame,
    output logic [7:0]                           color
);

    localparam int N  = MAP_COLS * MAP_ROWS;
    localparam int AW = $clog2(N);
    localparam int TL = TEX_LOG2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [1:0] mem [N];

    logic [AW-1:0]        init_addr_q, init_addr_d;
    logic [9:0]           init_col_q, init_col_d;
    logic [9:0]           init_row_q, init_row_d;
    logic                 map_ready_q, map_ready_d;
    logic [1:0]           map_rdata_q, map_rdata_d;
    logic [ANIM_BITS-1:0] anim_q, anim_d;

    logic          run;
    logic          b_in_range;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [1:0]    wr_data;

    logic [9:0]    px, py, col, row;
    logic          active;

    logic [AW-1:0] s0_addr_q, s0_addr_d;
    logic [TL-1:0] s0_tx_q, s0_tx_d, s0_ty_q, s0_ty_d;
    logic          s0_sub_q, s0_sub_d, s0_in_q, s0_in_d;

    logic [1:0]    ram_q;

    logic [TL-1:0] s1_tx_q, s1_ty_q;
    logic          s1_sub_q, s1_in_q;

    logic [TL-1:0] s2_tx_q, s2_ty_q;
    logic          s2_sub_q, s2_in_q;
    logic [1:0]    s2_tile_q;

    logic [TL-1:0]   tx;
    logic [1:0]      tex_id_q, tex_id_d;
    logic [2*TL-1:0] tex_addr_q, tex_addr_d;
    logic            s3_in_q, black_q, black_d;
    logic [7:0]      color_q, color_d;

    assign run        = (state_q == ST_RUN);
    assign b_in_range = ({1'b0, map_addr} < (AW+1)'(N));

    // Init sequencer: one cell per clock, then RUN until reset
    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        init_col_d  = init_col_q;
        init_row_d  = init_row_q;
        unique case (state_q)
            ST_INIT: begin
                if (init_addr_q == AW'(N - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    init_addr_d = init_addr_q + AW'(1);
                    if (init_col_q == 10'(MAP_COLS - 1)) begin
                        init_col_d = '0;
                        init_row_d = init_row_q + 10'd1;
                    end else begin
                        init_col_d = init_col_q + 10'd1;
                    end
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Single map write port shared by the init sequencer and port B
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (!run) begin
            wr_en   = 1'b1;
            wr_addr = init_addr_q;
            wr_data = (init_row_q == '0 || init_col_q == '0 ||
                       init_row_q == 10'(MAP_ROWS - 1) ||
                       init_col_q == 10'(MAP_COLS - 1)) ? 2'd1 : 2'd0;
        end else if (map_we && b_in_range) begin
            wr_en   = 1'b1;
            wr_addr = map_addr;
            wr_data = map_wdata;
        end
    end

    // Port B query, animation counter and ready flag
    always_comb begin
        map_rdata_d = map_rdata_q;
        anim_d      = anim_q;
        map_ready_d = run;
        if (run && !map_we) begin
            map_rdata_d = b_in_range ? mem[map_addr] : 2'd0;
        end
        if (run && anim_tick) begin
            anim_d = anim_q + ANIM_BITS'(1);
        end
    end

    // S0: screen position to tile address and in-tile texel
    always_comb begin
        px     = h_count - 10'(H_START);
        py     = v_count - 10'(V_START);
        col    = px >> TILE_LOG2;
        row    = py >> TILE_LOG2;
        active = ({1'b0, h_count} >= 11'(H_START)) &&
                 ({1'b0, h_count} <  11'(H_START + H_ACTIVE)) &&
                 ({1'b0, v_count} >= 11'(V_START)) &&
                 ({1'b0, v_count} <  11'(V_START + V_ACTIVE));
        s0_in_d   = active && (col < 10'(MAP_COLS)) && (row < 10'(MAP_ROWS));
        s0_addr_d = s0_in_d ? AW'(row * MAP_COLS + col) : '0;
        s0_tx_d   = px[TL-1:0];
        s0_ty_d   = py[TL-1:0];
        s0_sub_d  = (px[3] == py[3]);
    end

    // S2: tile type to texture select, flower pattern and mirroring
    always_comb begin
        tx       = s2_tx_q;
        tex_id_d = 2'd0;
        black_d  = 1'b0;
        unique case (s2_tile_q)
            2'd0: tex_id_d = 2'd0;
            2'd1: tex_id_d = 2'd1;
            2'd2: begin
                if (s2_sub_q) begin
                    tex_id_d = 2'd2;
                    if (!anim_q[ANIM_BITS-1]) begin
                        tx = ~s2_tx_q;
                    end
                end
            end
            2'd3: black_d = 1'b1;
            default: tex_id_d = 2'd0;
        endcase
        tex_addr_d = {s2_ty_q, tx};
        color_d    = (s3_in_q && !black_q && run) ? tex_data : 8'h00;
    end

    // Map RAM has no reset; render read is read-first against the write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        ram_q <= mem[s0_addr_q];
    end

    // Control state and render pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
            init_col_q  <= '0;
            init_row_q  <= '0;
            map_ready_q <= 1'b0;
            map_rdata_q <= '0;
            anim_q      <= '0;
            s0_addr_q   <= '0;
            s0_tx_q     <= '0;
            s0_ty_q     <= '0;
            s0_sub_q    <= 1'b0;
            s0_in_q     <= 1'b0;
            s1_tx_q     <= '0;
            s1_ty_q     <= '0;
            s1_sub_q    <= 1'b0;
            s1_in_q     <= 1'b0;
            s2_tx_q     <= '0;
            s2_ty_q     <= '0;
            s2_sub_q    <= 1'b0;
            s2_in_q     <= 1'b0;
            s2_tile_q   <= '0;
            tex_id_q    <= '0;
            tex_addr_q  <= '0;
            s3_in_q     <= 1'b0;
            black_q     <= 1'b0;
            color_q     <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            init_col_q  <= init_col_d;
            init_row_q  <= init_row_d;
            map_ready_q <= map_ready_d;
            map_rdata_q <= map_rdata_d;
            anim_q      <= anim_d;
            s0_addr_q   <= s0_addr_d;
            s0_tx_q     <= s0_tx_d;
            s0_ty_q     <= s0_ty_d;
            s0_sub_q    <= s0_sub_d;
            s0_in_q     <= s0_in_d;
            s1_tx_q     <= s0_tx_q;
            s1_ty_q     <= s0_ty_q;
            s1_sub_q    <= s0_sub_q;
            s1_in_q     <= s0_in_q;
            s2_tx_q     <= s1_tx_q;
            s2_ty_q     <= s1_ty_q;
            s2_sub_q    <= s1_sub_q;
            s2_in_q     <= s1_in_q;
            s2_tile_q   <= ram_q;
            tex_id_q    <= tex_id_d;
            tex_addr_q  <= tex_addr_d;
            s3_in_q     <= s2_in_q;
            black_q     <= black_d;
            color_q     <= color_d;
        end
    end

    assign map_rdata  = map_rdata_q;
    assign map_ready  = map_ready_q;
    assign tex_id     = tex_id_q;
    assign tex_addr   = tex_addr_q;
    assign anim_frame = anim_q;
    assign color      = color_q;

endmodule

// File: tb/tb_tile_map_renderer.sv
// tb_tile_map_renderer: directed vectors for the tile-map renderer,
// with a simple XOR texture ROM model.
module tb_tile_map_renderer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] h_count, v_count;
    logic       anim_tick, map_we;
    logic [8:0] map_addr;
    logic [1:0] map_wdata, map_rdata, tex_id;
    logic       map_ready;
    logic [7:0] tex_addr, tex_data, color;
    logic [3:0] anim_frame;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [9:0] h;
        logic [9:0] v;
        logic       chk_tex;
        logic [1:0] id;
        logic [7:0] ad;
        logic [7:0] col;
    } vec_t;

    vec_t vt[10];

    always #5 clk = ~clk;

    assign tex_data = 8'hA5 ^ tex_addr;

    tile_map_renderer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .h_count    (h_count),
        .v_count    (v_count),
        .anim_tick  (anim_tick),
        .map_we     (map_we),
        .map_addr   (map_addr),
        .map_wdata  (map_wdata),
        .map_rdata  (map_rdata),
        .map_ready  (map_ready),
        .tex_id     (tex_id),
        .tex_addr   (tex_addr),
        .tex_data   (tex_data),
        .anim_frame (anim_frame),
        .color      (color)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int start, output int n);
        n = start;
        while (!map_ready && n < 400) begin
            step();
            n++;
        end
    endtask

    task automatic query(input logic [8:0] a, input logic [1:0] exp,
                         input string name);
        map_we   = 1'b0;
        map_addr = a;
        step();
        chk(name, map_rdata, exp);
    endtask

    task automatic wr(input logic [8:0] a, input logic [1:0] d);
        map_we    = 1'b1;
        map_addr  = a;
        map_wdata = d;
        step();
        map_we    = 1'b0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            anim_tick = 1'b1;
            step();
            anim_tick = 1'b0;
            step();
        end
    endtask

    task automatic run_px(input logic [9:0] h, input logic [9:0] v,
                          output logic [1:0] id3,
                          output logic [7:0] ad3,
                          output logic [7:0] c4);
        h_count = h;
        v_count = v;
        step();
        h_count = 10'd0;
        v_count = 10'd0;
        repeat (2) @(posedge clk);
        step();
        id3 = tex_id;
        ad3 = tex_addr;
        step();
        c4 = color;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_color"}, color, 8'h00);
        chk({tag, "_tex_id"}, tex_id, 2'd0);
        chk({tag, "_tex_addr"}, tex_addr, 8'h00);
        chk({tag, "_rdata"}, map_rdata, 2'd0);
        chk({tag, "_ready"}, map_ready, 1'b0);
        chk({tag, "_anim"}, anim_frame, 4'd0);
    endtask

    initial begin
        logic [1:0] id;
        logic [7:0] ad, c;
        int n;

        vt[0] = '{10'd144, 10'd31,  1'b1, 2'd1, 8'h00, 8'hA5};
        vt[1] = '{10'd181, 10'd70,  1'b1, 2'd0, 8'h75, 8'hD0};
        vt[2] = '{10'd783, 10'd510, 1'b1, 2'd1, 8'hFF, 8'h5A};
        vt[3] = '{10'd752, 10'd231, 1'b1, 2'd1, 8'h80, 8'h25};
        vt[4] = '{10'd217, 10'd109, 1'b1, 2'd0, 8'hE9, 8'h4C};
        vt[5] = '{10'd100, 10'd31,  1'b0, 2'd0, 8'h00, 8'h00};
        vt[6] = '{10'd784, 10'd100, 1'b0, 2'd0, 8'h00, 8'h00};
        vt[7] = '{10'd200, 10'd511, 1'b0, 2'd0, 8'h00, 8'h00};
        vt[8] = '{10'd143, 10'd31,  1'b0, 2'd0, 8'h00, 8'h00};
        vt[9] = '{10'd144, 10'd30,  1'b0, 2'd0, 8'h00, 8'h00};

        rst_n     = 1'b0;
        h_count   = 10'd149;
        v_count   = 10'd38;
        anim_tick = 1'b0;
        map_we    = 1'b0;
        map_addr  = '0;
        map_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");

        // first init: port B and anim_tick must be ignored
        rst_n     = 1'b1;
        map_we    = 1'b1;
        map_addr  = 9'd5;
        map_wdata = 2'd3;
        anim_tick = 1'b1;
        for (int i = 0; i < 20; i++) step();
        map_we    = 1'b0;
        anim_tick = 1'b0;
        map_addr  = 9'd0;
        chk("init_color", color, 8'h00);
        chk("init_rdata", map_rdata, 2'd0);
        chk("init_anim", anim_frame, 4'd0);
        wait_ready(20, n);
        chk("init_len", n, 301);

        query(9'd0,   2'd1, "q0");
        query(9'd21,  2'd0, "q21");
        query(9'd299, 2'd1, "q299");
        query(9'd5,   2'd1, "q5");
        query(9'd42,  2'd0, "q42");

        for (int i = 0; i < 10; i++) begin
            run_px(vt[i].h, vt[i].v, id, ad, c);
            if (vt[i].chk_tex) begin
                chk($sformatf("vec%0d_tex_id", i), id, vt[i].id);
                chk($sformatf("vec%0d_tex_addr", i), ad, vt[i].ad);
            end
            chk($sformatf("vec%0d_color", i), c, vt[i].col);
        end

        // flower tile at cell 21, mirroring follows anim_frame MSB
        wr(9'd21, 2'd2);
        query(9'd21, 2'd2, "q21_flower");
        run_px(10'd179, 10'd63, id, ad, c);
        chk("flw0_tex_id", id, 2'd2);
        chk("flw0_tex_addr", ad, 8'h0C);
        chk("flw0_color", c, 8'hA9);
        run_px(10'd184, 10'd63, id, ad, c);
        chk("flw_grass_tex_id", id, 2'd0);
        chk("flw_grass_tex_addr", ad, 8'h08);
        tick(8);
        chk("anim8", anim_frame, 4'd8);
        run_px(10'd179, 10'd63, id, ad, c);
        chk("flw8_tex_id", id, 2'd2);
        chk("flw8_tex_addr", ad, 8'h03);
        chk("flw8_color", c, 8'hA6);
        tick(8);
        chk("anim_wrap", anim_frame, 4'd0);

        // same-cycle write of cell 42 against render read of cell 42
        h_count = 10'd209;
        v_count = 10'd95;
        step();
        h_count   = 10'd210;
        map_we    = 1'b1;
        map_addr  = 9'd42;
        map_wdata = 2'd3;
        step();
        map_we  = 1'b0;
        h_count = 10'd211;
        step();
        h_count = 10'd0;
        v_count = 10'd0;
        step();
        chk("coll_tex_addr", tex_addr, 8'h01);
        step();
        chk("coll_old_color", color, 8'hA4);
        step();
        chk("coll_new_color", color, 8'h00);
        step();
        chk("coll_next_color", color, 8'h00);

        // out-of-range port B access
        query(9'd0, 2'd1, "q0_pre_oob");
        wr(9'd300, 2'd3);
        query(9'd300, 2'd0, "q300");
        query(9'd44,  2'd0, "q44_after_oob");
        query(9'd299, 2'd1, "q299_after_oob");

        // steady brick pixel, then reset from RUN clears everything
        tick(3);
        map_addr = 9'd0;
        h_count  = 10'd144;
        v_count  = 10'd31;
        repeat (6) step();
        chk("steady_color", color, 8'hA5);
        chk("steady_anim", anim_frame, 4'd3);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("run_reset");

        // reset again midway through init
        step();
        h_count = 10'd149;
        v_count = 10'd38;
        rst_n   = 1'b1;
        for (int i = 0; i < 150; i++) step();
        chk("mid_tex_addr_pre", tex_addr, 8'h75);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        step();
        rst_n = 1'b1;
        wait_ready(0, n);
        chk("reinit_len", n, 301);
        query(9'd21, 2'd0, "q21_reinit");
        query(9'd42, 2'd0, "q42_reinit");
        query(9'd0,  2'd1, "q0_reinit");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
